// File: rtl/izigzag_router.sv
// Inverse-zigzag / raster token router for N x N blocks.
// Steers each accepted token to the channel equal to its column.
module izigzag_router #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mode,
  input  logic [W-1:0]  in_d,
  input  logic          in_v,
  input  logic          in_e,
  output logic          in_b,
  output logic [W-1:0]  out_d,
  output logic [N-1:0]  out_v,
  output logic [N-1:0]  out_e,
  input  logic [N-1:0]  out_b,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          blk_done,
  output logic          trunc
);

  typedef enum logic {UP, DN} dir_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  dir_t          r_dir;
  logic          r_mode;
  logic          r_blk_done;
  logic          r_trunc;

  logic          w_start;
  logic          w_last;
  logic          w_mode_eff;
  logic          w_acc_d;
  logic          w_acc_e;
  logic [CW-1:0] w_nrow;
  logic [CW-1:0] w_ncol;
  dir_t          w_ndir;

  assign w_start    = (r_row == '0) && (r_col == '0);
  assign w_last     = (r_row == LAST) && (r_col == LAST);
  // The first token of a block already walks in the newly sampled mode.
  assign w_mode_eff = w_start ? mode : r_mode;

  assign w_acc_d = reset & in_v & ~in_e & ~out_b[r_col];
  assign w_acc_e = reset & in_v & in_e & (out_b == '0);

  assign in_b     = ~(w_acc_d | w_acc_e);
  assign out_d    = in_d;
  assign row      = r_row;
  assign col      = r_col;
  assign blk_done = r_blk_done;
  assign trunc    = r_trunc;

  // Per-channel valid/eos: one-hot for data, broadcast for eos.
  always_comb begin
    out_v = '0;
    out_e = '0;
    if (w_acc_d) out_v[r_col] = 1'b1;
    if (w_acc_e) begin
      out_v = '1;
      out_e = '1;
    end
  end

  // Next walker position for an accepted data token.
  always_comb begin
    w_nrow = r_row;
    w_ncol = r_col;
    w_ndir = r_dir;
    if (w_last) begin
      w_nrow = '0;
      w_ncol = '0;
      w_ndir = UP;
    end else if (w_mode_eff) begin
      if (r_col == LAST) begin
        w_ncol = '0;
        w_nrow = r_row + ONE;
      end else begin
        w_ncol = r_col + ONE;
      end
    end else if (r_dir == UP) begin
      if (r_col == LAST) begin
        w_nrow = r_row + ONE;
        w_ndir = DN;
      end else if (r_row == '0) begin
        w_ncol = r_col + ONE;
        w_ndir = DN;
      end else begin
        w_nrow = r_row - ONE;
        w_ncol = r_col + ONE;
      end
    end else begin
      if (r_row == LAST) begin
        w_ncol = r_col + ONE;
        w_ndir = UP;
      end else if (r_col == '0) begin
        w_nrow = r_row + ONE;
        w_ndir = UP;
      end else begin
        w_nrow = r_row + ONE;
        w_ncol = r_col - ONE;
      end
    end
  end

  // Walker, mode latch and status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row      <= '0;
      r_col      <= '0;
      r_dir      <= UP;
      r_mode     <= 1'b0;
      r_blk_done <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      r_blk_done <= w_acc_d & w_last;
      r_trunc    <= w_acc_e & ~w_start;
      if (w_acc_d) begin
        r_row <= w_nrow;
        r_col <= w_ncol;
        r_dir <= w_ndir;
        if (w_start) r_mode <= mode;
      end else if (w_acc_e) begin
        r_row <= '0;
        r_col <= '0;
        r_dir <= UP;
      end
    end
  end

endmodule

// File: tb/tb_izigzag_router.sv
// Bench for izigzag_router: scan-order model plus directed vectors.
// Model derives positions from anti-diagonal ordering, not a walker.
module tb_izigzag_router;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = 3;
  localparam int NN = N * N;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode  = 1'b0;
  logic [W-1:0]  in_d  = '0;
  logic          in_v  = 1'b0;
  logic          in_e  = 1'b0;
  logic          in_b;
  logic [W-1:0]  out_d;
  logic [N-1:0]  out_v;
  logic [N-1:0]  out_e;
  logic [N-1:0]  out_b = '0;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          blk_done;
  logic          trunc;

  int n_chk = 0;
  int n_err = 0;

  izigzag_router #(.N(N), .W(W), .CW(CW)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .in_d(in_d), .in_v(in_v), .in_e(in_e), .in_b(in_b),
    .out_d(out_d), .out_v(out_v), .out_e(out_e), .out_b(out_b),
    .row(row), .col(col), .blk_done(blk_done), .trunc(trunc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Zigzag scan order built from anti-diagonals.
  int zr[NN];
  int zc[NN];
  initial begin
    int k;
    k = 0;
    for (int s = 0; s <= 2 * N - 2; s++) begin
      int lo, hi;
      lo = (s > N - 1) ? s - N + 1 : 0;
      hi = (s < N - 1) ? s : N - 1;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zr[k] = r; zc[k] = s - r; k++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zr[k] = r; zc[k] = s - r; k++;
        end
      end
    end
  end

  int mk = 0;
  bit mq = 0;
  bit eb = 0;
  bit et = 0;

  function automatic int mrow();
    return mq ? mk / N : zr[mk];
  endfunction

  function automatic int mcol();
    return mq ? mk % N : zc[mk];
  endfunction

  // Model: token index within block, latched mode, pulses.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mk = 0; mq = 0; eb = 0; et = 0;
    end else begin
      eb = 0;
      et = 0;
      if (in_v && !in_e && !out_b[mcol()]) begin
        if (mk == 0) mq = mode;
        mk++;
        if (mk == NN) begin
          mk = 0;
          eb = 1;
        end
      end else if (in_v && in_e && out_b == '0) begin
        et = (mk != 0);
        mk = 0;
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clock) begin
    logic [N-1:0] ev, ee;
    logic eib;
    ev = '0; ee = '0; eib = 1'b1;
    if (reset && in_v && !in_e && !out_b[mcol()]) begin
      ev[mcol()] = 1'b1;
      eib = 1'b0;
    end else if (reset && in_v && in_e && out_b == '0) begin
      ev = '1; ee = '1; eib = 1'b0;
    end
    chk("m_in_b", 32'(in_b), 32'(eib));
    chk("m_out_v", 32'(out_v), 32'(ev));
    chk("m_out_e", 32'(out_e), 32'(ee));
    chk("m_out_d", 32'(out_d), 32'(in_d));
    chk("m_row", 32'(row), 32'(mrow()));
    chk("m_col", 32'(col), 32'(mcol()));
    chk("m_blk", 32'(blk_done), 32'(eb));
    chk("m_trunc", 32'(trunc), 32'(et));
  end

  // One data token; expected channel < 0 means model-only.
  task automatic tok(input int ch);
    in_v = 1'b1;
    in_e = 1'b0;
    in_d = W'($urandom);
    @(negedge clock);
    if (ch >= 0) begin
      chk("lit_col", 32'(col), 32'(ch));
      chk("lit_v", 32'(out_v), 32'(1) << ch);
    end
    @(posedge clock); #1;
    in_v = 1'b0;
  endtask

  task automatic toks(input int n);
    for (int i = 0; i < n; i++) tok(-1);
  endtask

  task automatic eos();
    in_v = 1'b1;
    in_e = 1'b1;
    @(negedge clock);
    chk("lit_eos_v", 32'(out_v), 32'hFF);
    chk("lit_eos_e", 32'(out_e), 32'hFF);
    @(posedge clock); #1;
    in_v = 1'b0;
    in_e = 1'b0;
  endtask

  int zz0[10] = '{0, 1, 0, 0, 1, 2, 3, 2, 1, 0};

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_b", 32'(in_b), 32'(1));
    chk("rst_out_v", 32'(out_v), 32'(0));
    @(posedge clock); #1;
    reset = 1'b1;

    // Zigzag block with literal channel sequence.
    for (int i = 0; i < 10; i++) tok(zz0[i]);
    toks(51);
    tok(7); tok(6); tok(7);
    @(negedge clock);
    chk("lit_blk1", 32'(blk_done), 32'(1));
    @(negedge clock);
    chk("lit_blk0", 32'(blk_done), 32'(0));
    @(posedge clock); #1;
    tok(0);
    toks(63);

    // Raster block; mode dropped mid-block must not matter.
    mode = 1'b1;
    for (int i = 0; i < NN; i++) begin
      if (i == 20) mode = 1'b0;
      tok(i % N);
    end

    // Zigzag again; idx 2 returning to ch 0 proves the switch.
    for (int i = 0; i < 5; i++) tok(zz0[i]);

    // Backpressure on channel 2 while token 5 pending.
    out_b = 8'h04;
    in_v = 1'b1;
    in_d = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_in_b", 32'(in_b), 32'(1));
      chk("bp_out_v", 32'(out_v), 32'(0));
      chk("bp_rc", {16'(row), 16'(col)}, {16'd0, 16'd2});
      @(posedge clock); #1;
    end
    out_b = '0;
    @(negedge clock);
    chk("bp_rel_v", 32'(out_v), 32'h04);
    @(posedge clock); #1;
    in_v = 1'b0;
    @(negedge clock);
    chk("bp_rc_next", {16'(row), 16'(col)}, {16'd0, 16'd3});
    @(posedge clock); #1;
    toks(58);

    // EOS at boundary, first blocked by channel 4.
    out_b = 8'h10;
    in_v = 1'b1;
    in_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("eos_blk_in_b", 32'(in_b), 32'(1));
      chk("eos_blk_v", 32'(out_v), 32'(0));
      @(posedge clock); #1;
    end
    out_b = '0;
    eos();
    @(negedge clock);
    chk("lit_trunc0", 32'(trunc), 32'(0));
    @(posedge clock); #1;

    // EOS with a partial block outstanding.
    toks(10);
    eos();
    @(negedge clock);
    chk("lit_trunc1", 32'(trunc), 32'(1));
    @(posedge clock); #1;
    tok(0);
    tok(1);

    // Reset mid-block, in raster mode.
    @(posedge clock); #1;
    eos();
    mode = 1'b1;
    toks(30);
    reset = 1'b0;
    in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_mid_in_b", 32'(in_b), 32'(1));
      chk("rst_mid_v", 32'(out_v), 32'(0));
      chk("rst_mid_rc", {16'(row), 16'(col)}, 32'd0);
      @(posedge clock); #1;
    end
    in_v = 1'b0;
    mode = 1'b0;
    reset = 1'b1;
    tok(0); tok(1); tok(0);
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/izigzag_router.md
Name: izigzag_router

Overview:
- Parametrised successor to the fixed 8-channel inverse-zigzag distributor FSM.
- Accepts one serial coefficient stream in zigzag order and steers each token to the output channel equal to its column in an N x N block.
- Zigzag position is generated internally by a row/column walker; there are no external datapath flags.
- Adds a raster (bypass) mode, end-of-stream broadcast, and block and truncation status.

Parameters:
- N, 8: block dimension and number of output channels (N >= 2).
- W, 16: token data width.
- CW, 3: row/column counter width; must satisfy 2**CW >= N.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = zigzag, 1 = raster; sampled only at block start.
- in_d  in  W  input token data.
- in_v  in  1  input token valid.
- in_e  in  1  input token is end-of-stream (qualified by in_v).
- in_b  out  1  input backpressure; 1 = not accepted this cycle.
- out_d  out  W  output data, broadcast to all channels (equals in_d).
- out_v  out  N  per-channel valid.
- out_e  out  N  per-channel end-of-stream flag.
- out_b  in  N  per-channel backpressure from consumers.
- row  out  CW  current walker row.
- col  out  CW  current walker column (the selected channel).
- blk_done  out  1  one-cycle pulse on acceptance of the last token (N*N-th) of a block.
- trunc  out  1  one-cycle pulse when end-of-stream is accepted with a partial block outstanding.

Behaviour:
- Reset (asynchronous, active-low) sets: row=0, col=0, dir=up, mode_q=0, blk_done=0, trunc=0. Combinational outputs settle to: in_b=1, out_v=0, out_e=0.
- Combinational path, zero latency, same as the predecessor. out_d = in_d at all times.
- Data token (in_v=1, in_e=0):
  - sel = col.
  - When out_b[sel]=0: out_v[sel]=1, in_b=0, and the walker advances on the clock edge.
  - When out_b[sel]=1: in_b=1, out_v=0, and state is held.
  - Non-selected channels never see valid.
- Zigzag advance (mode_q=0):
  - Up, moving r-1 / c+1:
    - c==N-1: r+1, dir=down.
    - else r==0: c+1, dir=down.
    - else r-1, c+1.
  - Down, moving r+1 / c-1:
    - r==N-1: c+1, dir=up.
    - else c==0: r+1, dir=up.
    - else r+1, c-1.
- Raster advance (mode_q=1): c+1; when c==N-1, c=0 and r+1.
- Last token of a block is at r==N-1 and c==N-1 in both modes.
  - On its acceptance: r=0, c=0, dir=up, blk_done pulses the following cycle.
- mode is latched into mode_q only when a token is accepted at r==0 and c==0. A change to mode mid-block has no effect until the next block.
- End-of-stream token (in_v=1, in_e=1):
  - Broadcast to every channel; accepted only when out_b is all zeros.
  - On acceptance: out_v and out_e are all ones for that cycle, in_b=0, and the walker resets to (0,0,up).
  - Otherwise in_b=1 and nothing is asserted.
  - If the walker was not at (0,0) at acceptance, trunc pulses the following cycle.
- in_e with in_v=0 is ignored.
- blk_done and trunc are registered pulses and never exceed one cycle. Both are mutually exclusive.
- Reset asserted mid-block abandons the block. After release, the next token goes to channel 0.

Test Plan:
- Zigzag, N=8, out_b=0, tokens 0..9 -> channels 0,1,0,0,1,2,3,2,1,0; tokens 61,62,63 -> channels 7,6,7; blk_done pulses once after token 63; token 64 -> channel 0.
- Raster, mode=1 held at block start, 64 tokens -> channel = idx mod 8; mode toggled to 0 at idx 20 -> still raster until idx 64, zigzag from next block.
- Backpressure: out_b[2]=1 for 5 cycles while token 5 is pending -> in_b=1, no out_v, row/col=(0,2) held; release -> token 5 delivered on channel 2, walker to (0,3).
- EOS at block boundary with out_b=0 -> out_v=out_e=8'hFF for one cycle, trunc=0; EOS while out_b=8'h10 -> in_b=1 until cleared.
- EOS after 10 tokens -> broadcast, trunc pulses, next data token -> channel 0.
- Reset asserted after 30 tokens -> in_b=1, out_v=0 during reset; after release, token -> channel 0, row=col=0, mode_q=0.
